// File: rtl/fsqrt_arbiter.sv
// fsqrt_arbiter
// Shares one iterative Newton-Raphson single-precision square-root unit
// between two requesters. Arbitration is round-robin. The unit is launched
// with a one-cycle start pulse, its operand is held stable for the whole
// operation, and the result is captured and returned over a valid/ready
// handshake together with the source index and tag. A watchdog forces an
// error result (quiet NaN) if the unit never raises or never drops busy.
//
// Handshake rule (all valid/ready pairs here): a transfer happens on a rising
// clk edge where valid and ready are both high; a producer raising valid keeps
// it and its payload stable until that edge; ready may depend on valid.
//
// Ports
//   clk, clrn                 clock (rising edge), async active-low reset
//   reqN_valid/ready          request handshake, N = 0,1
//   reqN_d, reqN_rm, reqN_tag operand, rounding mode, requester tag
//   sq_d, sq_rm               operand / rounding mode to the sqrt unit (held)
//   sq_fsqrt                  one-cycle start pulse to the sqrt unit
//   sq_ena                    sqrt unit enable (low freezes the unit)
//   sq_busy, sq_s             sqrt unit busy flag and result
//   res_valid/ready           result handshake
//   res_s, res_src, res_tag   captured result, source index, tag
//   res_err                   watchdog fired, res_s forced to 32'h7fc00000
//   op_active                 high in every state except IDLE
//   dbg_state, dbg_rr         FSM state and round-robin pointer, for checkers

module fsqrt_arbiter #(
    parameter int TAG_W    = 4,
    parameter int DONE_LAT = 1,
    parameter int MAX_CYC  = 64
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_d,
    input  logic [1:0]       req0_rm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_d,
    input  logic [1:0]       req1_rm,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      sq_d,
    output logic [1:0]       sq_rm,
    output logic             sq_fsqrt,
    output logic             sq_ena,
    input  logic             sq_busy,
    input  logic [31:0]      sq_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_s,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             op_active,
    output logic [2:0]       dbg_state,
    output logic             dbg_rr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]  WD_LAST  = 8'(MAX_CYC - 1);
    localparam logic [2:0]  DLAT     = 3'(DONE_LAT);
    localparam logic [31:0] QNAN     = 32'h7fc00000;

    state_t             state;
    logic               rr;
    logic               seen_busy;
    logic [7:0]         wdog;
    logic [2:0]         dcnt;
    logic               src_q;
    logic [TAG_W-1:0]   tag_q;

    logic               grant_vld;
    logic               grant_idx;
    logic [31:0]        sel_d;
    logic [1:0]         sel_rm;
    logic [TAG_W-1:0]   sel_tag;
    logic [7:0]         wdog_nxt;
    logic               wdog_hit;

    // Grant: requester at rr first, otherwise the other one. Only in IDLE.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state == S_IDLE) begin
            if (rr == 1'b0) begin
                if (req0_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b0;
                end else if (req1_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b1;
                end
            end else begin
                if (req1_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b1;
                end else if (req0_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b0;
                end
            end
        end
    end

    assign req0_ready = grant_vld & ~grant_idx;
    assign req1_ready = grant_vld &  grant_idx;

    assign sel_d   = grant_idx ? req1_d   : req0_d;
    assign sel_rm  = grant_idx ? req1_rm  : req0_rm;
    assign sel_tag = grant_idx ? req1_tag : req0_tag;

    // The watchdog fires on the edge where the count would become MAX_CYC-1,
    // so res_valid rises exactly MAX_CYC cycles after the START cycle.
    assign wdog_nxt = wdog + 8'd1;
    assign wdog_hit = (wdog_nxt == WD_LAST);

    assign op_active = (state != S_IDLE);
    assign dbg_state = state;
    assign dbg_rr    = rr;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_IDLE;
            rr        <= 1'b0;
            seen_busy <= 1'b0;
            wdog      <= 8'd0;
            dcnt      <= 3'd0;
            src_q     <= 1'b0;
            tag_q     <= '0;
            sq_d      <= 32'd0;
            sq_rm     <= 2'd0;
            sq_fsqrt  <= 1'b0;
            sq_ena    <= 1'b0;
            res_valid <= 1'b0;
            res_s     <= 32'd0;
            res_src   <= 1'b0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else begin
            sq_fsqrt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        sq_d     <= sel_d;
                        sq_rm    <= sel_rm;
                        tag_q    <= sel_tag;
                        src_q    <= grant_idx;
                        rr       <= ~grant_idx;
                        sq_fsqrt <= 1'b1;
                        sq_ena   <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    seen_busy <= 1'b0;
                    wdog      <= 8'd0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    wdog <= wdog_nxt;
                    if (wdog_hit) begin
                        res_s     <= QNAN;
                        res_err   <= 1'b1;
                        res_src   <= src_q;
                        res_tag   <= tag_q;
                        res_valid <= 1'b1;
                        sq_ena    <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        if (sq_busy) begin
                            seen_busy <= 1'b1;
                        end
                        // Busy has risen and fallen again: the unit finished.
                        if (seen_busy && !sq_busy) begin
                            if (DONE_LAT == 0) begin
                                res_s     <= sq_s;
                                res_err   <= 1'b0;
                                res_src   <= src_q;
                                res_tag   <= tag_q;
                                res_valid <= 1'b1;
                                sq_ena    <= 1'b0;
                                state     <= S_DONE;
                            end else begin
                                dcnt  <= DLAT;
                                state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    wdog <= wdog_nxt;
                    if (wdog_hit) begin
                        res_s     <= QNAN;
                        res_err   <= 1'b1;
                        res_src   <= src_q;
                        res_tag   <= tag_q;
                        res_valid <= 1'b1;
                        sq_ena    <= 1'b0;
                        state     <= S_DONE;
                    end else if (dcnt == 3'd0) begin
                        res_s     <= sq_s;
                        res_err   <= 1'b0;
                        res_src   <= src_q;
                        res_tag   <= tag_q;
                        res_valid <= 1'b1;
                        sq_ena    <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        dcnt <= dcnt - 3'd1;
                    end
                end
                S_DONE: begin
                    // Going back through IDLE gives one idle cycle between
                    // the result handshake and the next accept.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Testbench for fsqrt_arbiter with a behavioural sqrt unit model
// (busy for 10 cycles, result valid one cycle after busy falls).
module tb_fsqrt_arbiter;

    localparam int TAG_W = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd2;

    logic             clk;
    logic             clrn;
    logic             req0_valid, req0_ready;
    logic [31:0]      req0_d;
    logic [1:0]       req0_rm;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [31:0]      req1_d;
    logic [1:0]       req1_rm;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      sq_d;
    logic [1:0]       sq_rm;
    logic             sq_fsqrt, sq_ena, sq_busy;
    logic [31:0]      sq_s;
    logic             res_valid, res_ready;
    logic [31:0]      res_s;
    logic             res_src;
    logic [TAG_W-1:0] res_tag;
    logic             res_err, op_active;
    logic [2:0]       dbg_state;
    logic             dbg_rr;

    fsqrt_arbiter #(.TAG_W(TAG_W), .DONE_LAT(1), .MAX_CYC(16)) dut (
        .clk(clk), .clrn(clrn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_d(req0_d),
        .req0_rm(req0_rm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_d(req1_d),
        .req1_rm(req1_rm), .req1_tag(req1_tag),
        .sq_d(sq_d), .sq_rm(sq_rm), .sq_fsqrt(sq_fsqrt), .sq_ena(sq_ena),
        .sq_busy(sq_busy), .sq_s(sq_s),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
        .res_src(res_src), .res_tag(res_tag), .res_err(res_err),
        .op_active(op_active), .dbg_state(dbg_state), .dbg_rr(dbg_rr)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- sqrt unit model ----------------
    int          model_mode;   // 0 normal, 1 busy stuck high, 2 busy never rises
    int          cnt_m;
    logic        pend_m;
    logic [31:0] res_m;

    function automatic logic [31:0] sqrt_lut(input logic [31:0] d);
        case (d)
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            default:      return 32'h00000000;
        endcase
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sq_busy <= 1'b0;
            cnt_m   <= 0;
            pend_m  <= 1'b0;
            res_m   <= 32'd0;
            sq_s    <= 32'd0;
        end else if (sq_ena) begin
            if (sq_fsqrt) begin
                cnt_m   <= 10;
                pend_m  <= 1'b0;
                sq_s    <= 32'hdeadbeef;
                res_m   <= sqrt_lut(sq_d);
                sq_busy <= (model_mode != 2);
            end else begin
                if (sq_busy && model_mode == 0) begin
                    if (cnt_m == 1) begin
                        sq_busy <= 1'b0;
                        pend_m  <= 1'b1;
                    end
                    cnt_m <= cnt_m - 1;
                end
                if (pend_m) begin
                    sq_s   <= res_m;
                    pend_m <= 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard / checking ----------------
    logic [37:0] exp_q[$];     // {err, src, tag, s}
    logic        grant_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          fsqrt_cnt = 0;
    int          acc_cyc[2];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // cycle counter and result monitor, sampled 1 ns after the falling edge
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (sq_fsqrt) fsqrt_cnt++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'({res_err, res_src, res_tag, res_s}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({res_err, res_src, res_tag, res_s}), 64'(e));
                end
                hs_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Called aligned 1 ns after a rising edge; returns 1 ns after the accept edge.
    task automatic do_req(input int p, input logic [31:0] d, input logic [1:0] rm,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp_s,
                          input logic exp_err);
        bit got;
        got = 1'b0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_d = d; req0_rm = rm; req0_tag = tag;
        end else begin
            req1_valid = 1'b1; req1_d = d; req1_rm = rm; req1_tag = tag;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            exp_q.push_back({exp_err, p[0], tag, exp_s});
            grant_q.push_back(p[0]);
            acc_cyc[p] = cyc;
        end else begin
            check("accept_timeout", 64'(0), 64'(1));
        end
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    // Counts cycles from the START cycle (k=1) to the first res_valid cycle,
    // and how many of those cycles sq_d differed from hold_d.
    task automatic wait_result(input logic [31:0] hold_d, output int k, output int bad);
        bad = 0;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            #2;
            if (sq_d !== hold_d) bad++;
            if (res_valid) begin
                k = i;
                break;
            end
        end
        if (k == 0) check("result_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (dbg_state == ST_IDLE && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, bad, f0;
        logic [37:0] snap;

        model_mode = 0;
        res_ready  = 1'b1;
        req0_valid = 1'b0; req0_d = 32'd0; req0_rm = 2'd0; req0_tag = '0;
        req1_valid = 1'b0; req1_d = 32'd0; req1_rm = 2'd0; req1_tag = '0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;

        // reset values, checked while clrn is low before any clock edge
        clrn = 1'b0;
        #3;
        check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
        check("rst_rr",        64'(dbg_rr), 64'(0));
        check("rst_res",       64'({res_valid, res_err, res_src, res_tag, res_s}), 64'(0));
        check("rst_sq",        64'({sq_d, sq_rm, sq_fsqrt, sq_ena}), 64'(0));
        check("rst_op_active", 64'(op_active), 64'(0));
        do_reset();

        // 1: single op, 4.0 -> 2.0, latency 1+11+1+1 = 14, one start pulse
        f0 = fsqrt_cnt;
        do_req(0, 32'h40800000, 2'd0, 4'd5, 32'h40000000, 1'b0);
        wait_result(32'h40800000, k, bad);
        check("s1_latency", 64'(k - 1), 64'(14));
        check("s1_res_valid_ena", 64'(sq_ena), 64'(0));
        wait_idle();
        check("s1_fsqrt_pulses", 64'(fsqrt_cnt - f0), 64'(1));

        // 2: both requesters continuously valid, strict alternation from rr=0
        do_reset();
        grant_q.delete();
        fork
            begin
                do_req(0, 32'h41100000, 2'd0, 4'd1, 32'h40400000, 1'b0);
                do_req(0, 32'h41100000, 2'd1, 4'd3, 32'h40400000, 1'b0);
            end
            begin
                do_req(1, 32'h41800000, 2'd2, 4'd2, 32'h40800000, 1'b0);
                do_req(1, 32'h41800000, 2'd3, 4'd4, 32'h40800000, 1'b0);
            end
        join
        wait_idle();
        check("s2_grant_count", 64'(grant_q.size()), 64'(4));
        if (grant_q.size() == 4)
            check("s2_grant_order", 64'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}), 64'(4'b0101));

        // 3: consumer stalls 10 cycles in DONE, req1 waiting
        res_ready = 1'b0;
        fork
            do_req(0, 32'h40800000, 2'd0, 4'd7, 32'h40000000, 1'b0);
            do_req(1, 32'h41100000, 2'd0, 4'd8, 32'h40400000, 1'b0);
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    #2;
                    if (res_valid) break;
                end
                snap = {res_err, res_src, res_tag, res_s};
                check("s3_snap", 64'(snap), 64'({1'b0, 1'b0, 4'd7, 32'h40000000}));
                bad = 0;
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        #2;
                    end
                    if ({res_err, res_src, res_tag, res_s} !== snap || sq_ena || req0_ready
                        || req1_ready || !op_active || !res_valid) bad++;
                end
                check("s3_done_hold", 64'(bad), 64'(0));
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        check("s3_accept_after_hs", 64'(acc_cyc[1]), 64'(hs_cyc + 1));
        wait_idle();

        // 4: busy stuck high -> watchdog 16 cycles after START, then normal op
        model_mode = 1;
        do_req(0, 32'h40800000, 2'd0, 4'd9, 32'h7fc00000, 1'b1);
        wait_result(32'h40800000, k, bad);
        check("s4_wdog_latency", 64'(k - 1), 64'(16));
        wait_idle();
        model_mode = 0;
        do_req(1, 32'h41100000, 2'd1, 4'd11, 32'h40400000, 1'b0);
        wait_result(32'h41100000, k, bad);
        check("s4_next_latency", 64'(k - 1), 64'(14));
        wait_idle();

        // 5: busy never rises -> watchdog, operand held throughout
        model_mode = 2;
        do_req(0, 32'h41800000, 2'd2, 4'd10, 32'h7fc00000, 1'b1);
        wait_result(32'h41800000, k, bad);
        check("s5_wdog_latency", 64'(k - 1), 64'(16));
        check("s5_sq_d_hold", 64'(bad), 64'(0));
        check("s5_sq_rm", 64'(sq_rm), 64'(2));
        wait_idle();
        model_mode = 0;

        // 6: reset mid-RUN drops the op; pending req1 then completes
        do_reset();
        fork
            do_req(0, 32'h40800000, 2'd0, 4'd12, 32'h40000000, 1'b0);
            do_req(1, 32'h41800000, 2'd0, 4'd13, 32'h40800000, 1'b0);
            begin
                repeat (4) @(negedge clk);
                #2;
                check("s6_mid_run", 64'(dbg_state), 64'(ST_RUN));
                check("s6_rr_before", 64'(dbg_rr), 64'(1));
                #1;
                clrn = 1'b0;
                #1;
                check("s6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
                check("s6_rst_valid", 64'(res_valid), 64'(0));
                check("s6_rst_rr", 64'(dbg_rr), 64'(0));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                @(posedge clk);
                #1;
                clrn = 1'b1;
            end
        join
        wait_result(32'h41800000, k, bad);
        check("s6_latency", 64'(k - 1), 64'(14));
        wait_idle();

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
